// File: rtl/mmio_fifo_ctrl.sv
// MMIO-mapped 64-bit FIFO with status, control and error-count registers.
// Read responses are registered and appear for one cycle after the request edge.
module mmio_fifo_ctrl #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [15:0] BASE_ADDR = 16'h0030
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_wr_valid,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_addr,
    input  logic [8:0]  mmio_tid,
    input  logic [63:0] mmio_wdata,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [15:0] OFF_DATA   = 16'd0;
    localparam logic [15:0] OFF_STATUS = 16'd2;
    localparam logic [15:0] OFF_CTRL   = 16'd4;
    localparam logic [15:0] OFF_ERR    = 16'd6;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic [31:0]   drop_cnt;
    logic [31:0]   empty_cnt;
    logic [15:0]   threshold;

    logic [15:0] addr_off;
    logic        in_window;
    logic        is_empty;
    logic        is_full;
    logic        push_req;
    logic        pop_req;
    logic        push_ok;
    logic        pop_ok;
    logic        push_drop;
    logic        pop_under;
    logic        ctl_wr;
    logic        do_flush;
    logic        do_clear;
    logic        do_load;
    logic [63:0] status_word;
    logic [63:0] rd_word;
    logic [CW-1:0] count_nxt;

    // Address decode, push/pop qualification and read mux (all from pre-edge state)
    always_comb begin
        addr_off    = mmio_addr - BASE_ADDR;
        in_window   = (addr_off <= OFF_ERR);
        is_empty    = (count == '0);
        is_full     = (count == CW'(DEPTH));
        push_req    = mmio_wr_valid && (addr_off == OFF_DATA);
        pop_req     = mmio_rd_valid && (addr_off == OFF_DATA);
        pop_ok      = pop_req && !is_empty;
        push_ok     = push_req && (!is_full || pop_ok);
        push_drop   = push_req && !push_ok;
        pop_under   = pop_req && is_empty;
        ctl_wr      = mmio_wr_valid && (addr_off == OFF_CTRL);
        do_flush    = ctl_wr && mmio_wdata[0];
        do_clear    = ctl_wr && mmio_wdata[1];
        do_load     = ctl_wr && mmio_wdata[2];
        status_word = {16'h0000, threshold, 11'h000, almost_full, underflow,
                       overflow, is_full, is_empty, 16'(count)};
        count_nxt   = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - CW'(1);
        end
        rd_word = 64'h0;
        case (addr_off)
            OFF_DATA:   rd_word = pop_ok ? mem[rd_ptr] : 64'h0;
            OFF_STATUS: rd_word = status_word;
            OFF_CTRL:   rd_word = {16'h0000, threshold, 32'h0};
            OFF_ERR:    rd_word = {empty_cnt, drop_cnt};
            default:    rd_word = 64'h0;
        endcase
    end

    // Storage has no reset; a push in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_ptr] <= mmio_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid   <= 1'b0;
            rsp_tid     <= '0;
            rsp_data    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            drop_cnt    <= '0;
            empty_cnt   <= '0;
            threshold   <= 16'(DEPTH);
            almost_full <= 1'b0;
        end else begin
            rsp_valid <= mmio_rd_valid && in_window;
            if (mmio_rd_valid && in_window) begin
                rsp_tid  <= mmio_tid;
                rsp_data <= rd_word;
            end

            if (do_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
                count <= count_nxt;
            end

            // Clear wins over any same-cycle flag set or counter increment
            if (do_clear) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
                drop_cnt  <= '0;
                empty_cnt <= '0;
            end else begin
                if (push_drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
                end
                if (pop_under) begin
                    underflow <= 1'b1;
                    if (empty_cnt != '1) empty_cnt <= empty_cnt + 32'd1;
                end
            end

            if (do_load) threshold <= mmio_wdata[47:32];
            almost_full <= (16'(count) >= threshold);
        end
    end

endmodule

// File: doc/mmio_fifo_ctrl.md
# mmio_fifo_ctrl

MMIO-mapped FIFO controller for the AFU's user register window. It decodes host MMIO writes and reads in a fixed address window. It pushes written data into an internal circular buffer and pops it on reads of the data register. It exposes status, control and error-count registers and drives a registered read response that the top-level AFU muxes onto the CCI-P c2 MMIO response channel.

## Interface
Parameters:
- DEPTH, 16: FIFO entries of 64 bits; power of two, ≥2.
- BASE_ADDR, 16'h0030: MMIO word address of the DATA register; window is BASE_ADDR..BASE_ADDR+6.

Ports:
- clk  in  1  sole clock; everything is on its rising edge.
- rst  in  1  synchronous, active-low reset (acts on clk edge while low).
- mmio_wr_valid  in  1  host MMIO write strobe (from rx.c0.mmioWrValid).
- mmio_rd_valid  in  1  host MMIO read strobe (from rx.c0.mmioRdValid).
- mmio_addr  in  16  MMIO word address (from the c0 MMIO header).
- mmio_tid  in  9  read transaction ID.
- mmio_wdata  in  64  write data.
- rsp_valid  out  1  one-cycle read-response strobe; asserted only for window hits.
- rsp_tid  out  9  TID echoed for the response.
- rsp_data  out  64  response data.
- almost_full  out  1  level; count ≥ threshold.

## Operation
- Registers (offsets from BASE_ADDR):
  - +0 DATA: write pushes; read pops.
  - +2 STATUS (read-only): [W-1:0] count, where W = log2(DEPTH)+1, zero-extended to 16 bits in [15:0]; [16] empty; [17] full; [18] overflow sticky; [19] underflow sticky; [20] almost_full; [47:32] threshold; other bits 0.
  - +4 CONTROL: write [0] = flush (pointers and count to 0, data contents don't care); write [1] = clear sticky flags and both drop counters; write [2] = load threshold from [47:32]. Reads return {threshold in [47:32], zeros}.
  - +6 ERRCNT (read-only): [31:0] dropped pushes; [63:32] empty pops. Each saturates at all-ones.
- Push when full: data is discarded, pointers are unchanged, overflow is set, and the dropped-push count is incremented.
- Pop when empty: rsp_data = 0, underflow is set, the empty-pop count is incremented, and rsp_valid still asserts.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count ranges 0..DEPTH.
- Writes to addresses outside the window, or to read-only registers, are ignored.
- Reads outside the window produce no response: rsp_valid stays 0 and the top level owns those addresses.
- CONTROL with both [0] and [1] set does both actions. [1] takes priority over a counter increment in the same cycle.
- almost_full = (count ≥ threshold). Threshold 0 makes it constantly 1. Threshold > DEPTH makes it never assert.
- mmio_wr_valid and mmio_rd_valid in the same cycle are both processed. A read sees the state from before the write:
  - push+pop on DATA with count = 0: the pop underflows and the push lands (count becomes 1).
  - push+pop on DATA with count = DEPTH: the pop returns the head, the push is accepted, and count stays DEPTH.
  - push+pop otherwise: count is unchanged.

## Timing
- Reset (rst=0 at an edge) sets: rsp_valid=0, rsp_tid=0, rsp_data=0, pointers=0, count=0, sticky flags=0, counters=0, threshold=DEPTH, almost_full=0.
- Reset mid-operation discards all queued data. A request presented in the reset cycle is dropped with no response.
- Read latency:
  - Request at edge N gives rsp_valid=1 with tid/data for the full cycle after N.
  - rsp_valid is high for exactly one cycle per hit.
  - Back-to-back reads give back-to-back responses.
- Write effects appear at edge N. A read at N+1 observes the new count/flags.
- almost_full is registered and updates one cycle after the count change.
- rsp_tid and rsp_data hold their last value when rsp_valid=0.

## Test plan
- Reset, then read STATUS (+2) -> rsp_valid one cycle later; data = 64'h0000_0010_0001_0000 (threshold 16, empty), for DEPTH=16.
- Push 0x11..0x13, then pop 3 times with TIDs 5, 6, 7 -> data 0x11, 0x12, 0x13 with matching TIDs; STATUS count 0, empty=1.
- Push 17 values into DEPTH=16 -> STATUS full=1, overflow=1, count 16; ERRCNT = 64'h0000_0000_0000_0001. Popping 16 returns the first 16 values in order, with pointer wrap verified.
- Pop when empty -> data 0, underflow=1, ERRCNT[63:32]=1. Then write CONTROL 2 -> flags=0 and ERRCNT=0 on the next read.
- Write CONTROL {threshold=4, bit2} and push 4 -> almost_full=1 one cycle after the 4th push. Write CONTROL 1 (flush) -> count 0, almost_full=0.
- Assert rst low mid-stream with 5 entries and a simultaneous read -> no response; afterwards STATUS reports empty and counters are 0.
